// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared across the minicpu pipeline.
//   XLEN           datapath width
//   MIPS_NOP       bubble encoding (sll r0,r0,0)
//   MIPS_RESET_PC  boot vector
//   MIPS_SYSCALL   syscall encoding
//   fetch_state_e  fetch handshake state (REQ, FULL)
//   fetch_entry_t  fetched instruction together with its address
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] MIPS_NOP      = 32'h0000_0000;
  localparam logic [XLEN-1:0] MIPS_RESET_PC = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] MIPS_SYSCALL  = 32'h0000_000C;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_FULL = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_skid.sv
// ifetch_skid: one-entry buffer holding a fetched instruction that could not
// advance into I1 in the cycle it arrived.
//   clk    clock
//   rst    synchronous active-high reset
//   load   capture din (takes priority over drain)
//   drain  entry consumed this cycle
//   din    instruction + address to capture
//   valid  entry present
//   dout   buffered instruction + address
module ifetch_skid
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  fetch_entry_t din,
  output logic         valid,
  output fetch_entry_t dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction-fetch stage. Holds the PC, runs the IReq/IAck handshake
// with instruction memory, and produces the stage-2 (I1) and stage-3 (I2)
// instructions consumed by decode. Handles branch redirects with one delay
// slot, downstream stalls and an optional two-cycle syscall stall.
//   CLK, MRST          clock, synchronous active-high reset
//   IAddr, IReq        fetch address (the PC) and request
//   IAck, IData        memory response, IData valid while IAck=1
//   Stall              downstream freeze
//   Redirect, RedirectPC  taken branch/jump and its target
//   instIsSyscall      decode flag, combinational on I1
//   I1, I2, PC1        stage-2/stage-3 instructions, address of I1
// Build option: IFETCH_SYSCALL_STALL_EN enables the syscall stall; without it
// instIsSyscall is ignored.
module ifetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = MIPS_RESET_PC,
  parameter logic [XLEN-1:0] NOP      = MIPS_NOP
) (
  input  logic            CLK,
  input  logic            MRST,
  output logic [XLEN-1:0] IAddr,
  output logic            IReq,
  input  logic            IAck,
  input  logic [XLEN-1:0] IData,
  input  logic            Stall,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectPC,
  input  logic            instIsSyscall,
  output logic [XLEN-1:0] I1,
  output logic [XLEN-1:0] I2,
  output logic [XLEN-1:0] PC1
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic            pend_q;
  logic [XLEN-1:0] pend_pc_q;
  logic            ack;
  logic            adv;
  logic            skid_load, skid_drain, skid_valid;
  fetch_entry_t    skid_out;

  // A response is only meaningful while a request is outstanding.
  assign ack   = IAck && (state_q == ST_REQ);
  assign IAddr = pc_q;
  assign IReq  = (state_q == ST_REQ);

`ifdef IFETCH_SYSCALL_STALL_EN
  logic [1:0] sys_cnt;
  logic       sys_done;
  logic       sys_trig;

  // Trigger once per syscall; sys_done blocks a retrigger while it sits in I1.
  assign sys_trig = instIsSyscall && !sys_done;
  assign adv      = !Stall && (sys_cnt == 2'd0);

  // Syscall bubble counter
  always_ff @(posedge CLK) begin
    if (MRST) begin
      sys_cnt  <= 2'd0;
      sys_done <= 1'b0;
    end else if (sys_trig) begin
      sys_cnt  <= 2'd2;
      sys_done <= 1'b1;
    end else begin
      if ((sys_cnt != 2'd0) && !Stall) sys_cnt <= sys_cnt - 2'd1;
      if (adv) sys_done <= 1'b0;
    end
  end
`else
  logic sys_unused;
  assign sys_unused = instIsSyscall;
  assign adv        = !Stall;
`endif

  // Fetch handshake state register
  always_ff @(posedge CLK) begin
    if (MRST) state_q <= ST_REQ;
    else      state_q <= state_d;
  end

  // Fetch handshake next state and skid controls
  always_comb begin
    state_d    = state_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (ack && !adv) begin
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (adv) begin
          skid_drain = 1'b1;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  ifetch_skid u_skid (
    .clk   (CLK),
    .rst   (MRST),
    .load  (skid_load),
    .drain (skid_drain),
    .din   ('{data: IData, addr: pc_q}),
    .valid (skid_valid),
    .dout  (skid_out)
  );

  // PC and pending redirect; the fetch in flight or buffered is the delay slot.
  always_ff @(posedge CLK) begin
    if (MRST) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else if (ack) begin
      if (Redirect) begin
        pc_q   <= RedirectPC;
        pend_q <= 1'b0;
      end else if (pend_q) begin
        pc_q   <= pend_pc_q;
        pend_q <= 1'b0;
      end else begin
        pc_q   <= pc_q + XLEN'(4);
      end
    end else if (Redirect) begin
      pend_q    <= 1'b1;
      pend_pc_q <= RedirectPC;
    end
  end

  // Stage registers: advance, bubble into I2 during a syscall stall, or hold.
  always_ff @(posedge CLK) begin
    if (MRST) begin
      I1  <= NOP;
      I2  <= NOP;
      PC1 <= '0;
    end else if (adv) begin
      I2 <= I1;
      if (skid_valid) begin
        I1  <= skid_out.data;
        PC1 <= skid_out.addr;
      end else if (ack) begin
        I1  <= IData;
        PC1 <= pc_q;
      end else begin
        I1  <= NOP;
      end
    end else if (!Stall) begin
      I2 <= NOP;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch. Directed vector table, hand-written
// reset and syscall sequences, then random traffic against a queue-based model.
module tb_ifetch;
  import mips_pkg::*;

`ifdef IFETCH_SYSCALL_STALL_EN
  localparam bit SYS_EN = 1'b1;
`else
  localparam bit SYS_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        MRST, IAck, Stall, Redirect, instIsSyscall;
  logic [31:0] IData, RedirectPC;
  logic [31:0] IAddr, I1, I2, PC1;
  logic        IReq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  ifetch dut (
    .CLK           (CLK),
    .MRST          (MRST),
    .IAddr         (IAddr),
    .IReq          (IReq),
    .IAck          (IAck),
    .IData         (IData),
    .Stall         (Stall),
    .Redirect      (Redirect),
    .RedirectPC    (RedirectPC),
    .instIsSyscall (instIsSyscall),
    .I1            (I1),
    .I2            (I2),
    .PC1           (PC1)
  );

  typedef struct {
    logic        stall, ack, redir;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic        ireq;
    logic [31:0] i1, i2, pc1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge. Decode's
  // syscall flag is emulated from the new I1.
  task automatic tick();
    @(posedge CLK);
    #1;
    instIsSyscall = (I1 == MIPS_SYSCALL);
  endtask

  task automatic do_reset();
    MRST = 1'b1; IAck = 1'b0; Stall = 1'b0; Redirect = 1'b0;
    RedirectPC = '0; IData = '0;
    repeat (2) tick();
    MRST = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic ak, input logic rd, input logic [31:0] rp,
                              input logic [31:0] ad, input logic rq, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] p);
    vec_t v;
    v.stall = st; v.ack = ak; v.redir = rd; v.rpc = rp;
    v.addr = ad; v.ireq = rq; v.i1 = a; v.i2 = b; v.pc1 = p;
    return v;
  endfunction

  vec_t        vecs[15];
  logic [31:0] exp_sys[6];

  // Reference model state
  logic [31:0] m_pc, m_pend_pc, m_i1, m_i2, m_pc1;
  logic        m_pend, m_done, m_ireq;
  int          m_cnt;
  logic [63:0] q[$];

  initial begin
    MRST = 1'b1; IAck = 1'b0; Stall = 1'b0; Redirect = 1'b0;
    RedirectPC = '0; IData = '0; instIsSyscall = 1'b0;

    // Memory returns {addr[31:2], 2'b01} so every word is tagged by its address.
    vecs[0]  = mk(0, 1, 0, 32'h0,        32'hBFC00004, 1, 32'hBFC00001, 32'h0,        32'hBFC00000);
    vecs[1]  = mk(0, 1, 0, 32'h0,        32'hBFC00008, 1, 32'hBFC00005, 32'hBFC00001, 32'hBFC00004);
    vecs[2]  = mk(1, 1, 0, 32'h0,        32'hBFC0000C, 0, 32'hBFC00005, 32'hBFC00001, 32'hBFC00004);
    vecs[3]  = mk(1, 0, 0, 32'h0,        32'hBFC0000C, 0, 32'hBFC00005, 32'hBFC00001, 32'hBFC00004);
    vecs[4]  = mk(1, 0, 0, 32'h0,        32'hBFC0000C, 0, 32'hBFC00005, 32'hBFC00001, 32'hBFC00004);
    vecs[5]  = mk(0, 0, 0, 32'h0,        32'hBFC0000C, 1, 32'hBFC00009, 32'hBFC00005, 32'hBFC00008);
    vecs[6]  = mk(0, 1, 0, 32'h0,        32'hBFC00010, 1, 32'hBFC0000D, 32'hBFC00009, 32'hBFC0000C);
    vecs[7]  = mk(0, 0, 1, 32'h00400100, 32'hBFC00010, 1, 32'h0,        32'hBFC0000D, 32'hBFC0000C);
    vecs[8]  = mk(0, 1, 0, 32'h0,        32'h00400100, 1, 32'hBFC00011, 32'h0,        32'hBFC00010);
    vecs[9]  = mk(0, 1, 0, 32'h0,        32'h00400104, 1, 32'h00400101, 32'hBFC00011, 32'h00400100);
    vecs[10] = mk(0, 1, 1, 32'h00000FFC, 32'h00000FFC, 1, 32'h00400105, 32'h00400101, 32'h00400104);
    vecs[11] = mk(0, 1, 0, 32'h0,        32'h00001000, 1, 32'h00000FFD, 32'h00400105, 32'h00000FFC);
    vecs[12] = mk(0, 1, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 32'h00001001, 32'h00000FFD, 32'h00001000);
    vecs[13] = mk(0, 1, 0, 32'h0,        32'h00000000, 1, 32'hFFFFFFFD, 32'h00001001, 32'hFFFFFFFC);
    vecs[14] = mk(0, 1, 0, 32'h0,        32'h00000004, 1, 32'h00000001, 32'hFFFFFFFD, 32'h00000000);

    // ---- reset state ----
    do_reset();
    check("rst IAddr", IAddr, 32'hBFC00000);
    check("rst IReq", 32'(IReq), 32'd1);
    check("rst I1", I1, 32'h0);
    check("rst I2", I2, 32'h0);
    check("rst PC1", PC1, 32'h0);

    // ---- directed vectors: stream, stall/skid, delay-slot redirect, wrap ----
    for (int i = 0; i < 15; i++) begin
      Stall = vecs[i].stall; IAck = vecs[i].ack;
      Redirect = vecs[i].redir; RedirectPC = vecs[i].rpc;
      IData = {IAddr[31:2], 2'b01};
      tick();
      check($sformatf("vec%0d IAddr", i), IAddr, vecs[i].addr);
      check($sformatf("vec%0d IReq", i), 32'(IReq), 32'(vecs[i].ireq));
      check($sformatf("vec%0d I1", i), I1, vecs[i].i1);
      check($sformatf("vec%0d I2", i), I2, vecs[i].i2);
      check($sformatf("vec%0d PC1", i), PC1, vecs[i].pc1);
    end
    Stall = 1'b0; IAck = 1'b0; Redirect = 1'b0;

    // ---- reset asserted while the skid buffer is full ----
    Stall = 1'b1; IAck = 1'b1; IData = {IAddr[31:2], 2'b01};
    tick();
    check("full IReq", 32'(IReq), 32'd0);
    MRST = 1'b1; IAck = 1'b0;
    tick();
    check("midrst I1", I1, 32'h0);
    check("midrst I2", I2, 32'h0);
    check("midrst IAddr", IAddr, 32'hBFC00000);
    check("midrst IReq", 32'(IReq), 32'd1);
    check("midrst PC1", PC1, 32'h0);
    // Response coinciding with reset is dropped.
    Stall = 1'b0; IAck = 1'b1; IData = 32'h12345671;
    tick();
    check("rstack IAddr", IAddr, 32'hBFC00000);
    check("rstack I1", I1, 32'h0);
    MRST = 1'b0; IAck = 1'b0;

    // ---- syscall in the stream, zero-wait memory ----
    do_reset();
    if (SYS_EN) begin
      exp_sys[0] = 32'h0;          exp_sys[1] = MIPS_SYSCALL; exp_sys[2] = 32'h0;
      exp_sys[3] = 32'h0;          exp_sys[4] = 32'hBFC00005; exp_sys[5] = 32'hBFC00009;
    end else begin
      exp_sys[0] = 32'h0;          exp_sys[1] = MIPS_SYSCALL; exp_sys[2] = 32'hBFC00005;
      exp_sys[3] = 32'hBFC00009;   exp_sys[4] = 32'hBFC0000D; exp_sys[5] = 32'hBFC00011;
    end
    for (int k = 0; k < 6; k++) begin
      IAck  = IReq;
      IData = (IAddr == 32'hBFC00000) ? MIPS_SYSCALL : {IAddr[31:2], 2'b01};
      tick();
      check($sformatf("sys I2 cycle%0d", k), I2, exp_sys[k]);
    end
    IAck = 1'b0;

    // ---- random traffic against the reference model ----
    do_reset();
    m_pc = MIPS_RESET_PC; m_pend = 1'b0; m_pend_pc = '0;
    m_i1 = MIPS_NOP; m_i2 = MIPS_NOP; m_pc1 = '0;
    m_cnt = 0; m_done = 1'b0; m_ireq = 1'b1;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic        st, rd, ak, adv, trig;
      logic [31:0] rp, dat;
      logic [63:0] e;
      st  = ($urandom_range(3) == 0);
      rd  = ($urandom_range(7) == 0);
      rp  = {$urandom() >> 2, 2'b00};
      ak  = m_ireq && ($urandom_range(2) != 0);
      dat = ($urandom_range(11) == 0) ? MIPS_SYSCALL : {m_pc[31:2], 2'b01};
      Stall = st; Redirect = rd; RedirectPC = rp; IAck = ak; IData = dat;

      // Fetch side: address stream and delivered-instruction queue.
      adv  = !st && (m_cnt == 0);
      trig = SYS_EN && (m_i1 == MIPS_SYSCALL) && !m_done;
      if (ak) begin
        q.push_back({dat, m_pc});
        if (rd) begin m_pc = rp; m_pend = 1'b0; end
        else if (m_pend) begin m_pc = m_pend_pc; m_pend = 1'b0; end
        else m_pc = m_pc + 32'd4;
      end else if (rd) begin
        m_pend = 1'b1; m_pend_pc = rp;
      end
      // Pipeline side.
      if (adv) begin
        m_i2 = m_i1;
        if (q.size() > 0) begin
          e = q.pop_front();
          m_i1 = e[63:32]; m_pc1 = e[31:0];
        end else begin
          m_i1 = MIPS_NOP;
        end
      end else if (!st) begin
        m_i2 = MIPS_NOP;
      end
      if (trig) begin
        m_cnt = 2; m_done = 1'b1;
      end else begin
        if (m_cnt != 0 && !st) m_cnt--;
        if (adv) m_done = 1'b0;
      end
      m_ireq = (q.size() == 0);

      tick();
      check($sformatf("rnd%0d IAddr", c), IAddr, m_pc);
      check($sformatf("rnd%0d IReq", c), 32'(IReq), 32'(m_ireq));
      check($sformatf("rnd%0d I1", c), I1, m_i1);
      check($sformatf("rnd%0d I2", c), I2, m_i2);
      check($sformatf("rnd%0d PC1", c), PC1, m_pc1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage of the minicpu pipeline, directly upstream of decode. Holds the PC, runs a request/acknowledge handshake to instruction memory, and drives the stage-2 instruction `I1` and stage-3 instruction `I2` that decode consumes. Handles branch redirects, external stalls and the two-cycle syscall stall requested by decode through `instIsSyscall`.

## Interface
- `RESET_PC`, default 32'hBFC00000: PC loaded on reset.
- `NOP`, default 32'h00000000: bubble encoding (`sll r0,r0,0`).

Ports:
- `CLK` in 1: clock; every register updates on its rising edge.
- `MRST` in 1: reset, synchronous, active-high.
- `IAddr` out 32: fetch address; equals `PC`.
- `IReq` out 1: fetch request.
- `IAck` in 1: instruction memory returns `IData` this cycle.
- `IData` in 32: fetched instruction; valid only while `IAck`=1.
- `Stall` in 1: hazard freeze from downstream.
- `Redirect` in 1: single-cycle pulse, branch or jump taken.
- `RedirectPC` in 32: target address; sampled only while `Redirect`=1.
- `instIsSyscall` in 1: from decode, combinational on `I1`.
- `I1` out 32: stage-2 instruction, fed to decode.
- `I2` out 32: stage-3 instruction.
- `PC1` out 32: address of `I1`.

## Operation
- Reset values: `PC`=`RESET_PC`, `I1`=`I2`=`NOP`, `PC1`=0, buffer empty, no redirect pending, syscall counter 0, state REQ.
- **FSM**
  - REQ: `IReq`=1. `IAck` with `adv`=1 sends `IData` straight to `I1` and stays in REQ. `IAck` with `adv`=0 writes the skid buffer and moves to FULL.
  - FULL: `IReq`=0. `adv`=1 moves the buffer into `I1` and returns to REQ.
- **PC update:** on every `IAck`, `PC` <= pending target if one is set (then clear pending), else `PC`+4. `PC` wraps modulo 2^32.
- **Redirect:** `Redirect` sets pending target = `RedirectPC`. A newer `Redirect` overwrites an older pending one. The fetch already in flight or buffered is the delay slot and is kept. If `Redirect` and `IAck` coincide, `PC` <= `RedirectPC` that same edge.
- **`adv`:** `!Stall && sysCnt==0 && !sysHold`.
  - `adv`=1 with an instruction available (buffer or `IAck`): `I2`<=`I1`, `I1`<=instruction, `PC1`<=its address.
  - `adv`=1 with no instruction available: `I2`<=`I1`, `I1`<=`NOP`.
  - `Stall`=1: `I1`, `I2`, `PC1` all held.
- **Syscall stall:** the first cycle `instIsSyscall`=1 with `sysDone`=0 loads `sysCnt`=2 and sets `sysDone`.
  - While `sysCnt`≠0: `I1` held, `I2`<=`NOP`, `sysCnt` decrements. `Stall` pauses the decrement.
  - `sysDone` clears when `I1` advances, so the same syscall never retriggers.
- `MRST` mid-operation wins over everything. An outstanding `IAck` in the reset cycle is dropped.

## Timing
- Zero-wait memory (`IAck` in the same cycle as `IReq`): one instruction per cycle. Fetch at edge N reaches `I1` at N, `I2` at N+1.
- First `IReq` is the cycle after `MRST` deasserts; first valid `I1` appears one edge later.
- `IReq` falls the cycle after the buffer fills and rises the cycle it drains. At most one instruction is outstanding.
- Syscall: exactly 2 `NOP` cycles in `I2` following the syscall entering `I2`, when `Stall`=0.

## Configuration
- `IFETCH_SYSCALL_STALL_EN` defined: syscall stall behaves as above.
- Undefined: `instIsSyscall` is ignored; `sysCnt` and `sysDone` are not built.

## Structure
- Shared package `mips_pkg` holds the `NOP` constant, the FSM state encoding (REQ, FULL) and the reset PC value.
- One sub-module, `ifetch_skid`: one-entry buffer (data, address, valid) with load/drain controls.
- PC, redirect, syscall logic and the stage registers stay in `ifetch`.

## Test plan
- Reset then `IAck`=1 every cycle returning addr-tagged data: `IAddr` sequence BFC00000, BFC00004, …; `I1` follows one edge behind; `I2` one edge after `I1`.
- `Stall` high 3 cycles with `IAck`=1: buffer fills, `IReq`=0 for the stall, `I1`/`I2` frozen; after release no instruction is lost or duplicated.
- `Redirect` with `RedirectPC`=0x00400100 while fetch of 0xBFC00010 is pending: 0xBFC00010 still reaches `I1` (delay slot); next `IAddr`=0x00400100.
- `IData`=0x0000000C (syscall) reaches `I1`: `I2` shows the syscall, then `NOP`, `NOP`; the next instruction follows with no retrigger.
- `MRST` asserted mid-FULL: next cycle `I1`=`I2`=`NOP`, `PC`=`RESET_PC`, `IReq`=1.
- Build without `IFETCH_SYSCALL_STALL_EN`, syscall in stream: no `NOP`s inserted.
